// File: rtl/configurable_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Package : div_pkg
//  Shared mode and state encodings for the configurable divider.
//  Revision: 1.0  initial release
// ============================================================================
package div_pkg;

    localparam logic [1:0] CM_SINGLE8  = 2'b00;
    localparam logic [1:0] CM_DUAL8    = 2'b01;
    localparam logic [1:0] CM_SINGLE16 = 2'b10;
    localparam logic [1:0] CM_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/configurable_divider_core.sv
`default_nettype none
// ============================================================================
//  Module  : restoring_divide_core
//  One signed restoring-division lane; optionally runs on its lower half only.
//  Revision: 1.0  initial release
// ============================================================================
module restoring_divide_core
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start,
    input  logic         narrow,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dbz,
    output logic         done
);

    localparam int H  = W / 2;
    localparam int CW = $clog2(W);

    logic [W-1:0]  a_q, a_d, dvd_q, dvd_d, quo_q, quo_d, div_q, div_d;
    logic [W:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, done_q, done_d, dbz_q, dbz_d;
    logic          narrow_q, narrow_d, negq_q, negq_d, negr_q, negr_d;

    logic [W-1:0]  a_ext, b_ext, a_mag, b_mag;
    logic [W:0]    rem_sh, diff;
    logic [CW-1:0] last;
    logic          ge;

    // Narrow operands are sign-extended from the lower half before magnitude conversion
    assign a_ext  = narrow ? {{H{a[H-1]}}, a[H-1:0]} : a;
    assign b_ext  = narrow ? {{H{b[H-1]}}, b[H-1:0]} : b;
    assign a_mag  = a_ext[W-1] ? -a_ext : a_ext;
    assign b_mag  = b_ext[W-1] ? -b_ext : b_ext;
    assign rem_sh = {rem_q[W-1:0], dvd_q[W-1]};
    assign diff   = rem_sh - {1'b0, div_q};
    assign ge     = ~diff[W];
    assign last   = narrow_q ? CW'(H - 1) : CW'(W - 1);

    always_comb begin
        a_d      = a_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = done_q;
        dbz_d    = dbz_q;
        narrow_d = narrow_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        if (start) begin
            a_d      = a;
            // A narrow dividend is pre-shifted so only H iterations are needed
            dvd_d    = narrow ? (a_mag << H) : a_mag;
            div_d    = b_mag;
            quo_d    = '0;
            rem_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
            done_d   = 1'b0;
            dbz_d    = (b_ext == '0);
            narrow_d = narrow;
            negq_d   = a_ext[W-1] ^ b_ext[W-1];
            negr_d   = a_ext[W-1];
        end else if (run_q) begin
            rem_d = ge ? diff : rem_sh;
            quo_d = {quo_q[W-2:0], ge};
            dvd_d = {dvd_q[W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == last) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_q      <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            narrow_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            narrow_q <= narrow_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    assign q    = dbz_q ? {W{1'b1}} : (negq_q ? -quo_q : quo_q);
    assign r    = dbz_q ? a_q : (negr_q ? -rem_q[W-1:0] : rem_q[W-1:0]);
    assign dbz  = dbz_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/configurable_divider.sv
`default_nettype none
// ============================================================================
//  Module  : configurable_divider
//  Sequential signed divider: one 8b, two parallel 8b, or one 16b divide.
//  Revision: 1.0  initial release
// ============================================================================
module configurable_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int LANE_W = WIDTH / 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [1:0]       cm_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic [1:0]       div_by_zero_o,
    output logic             busy_o,
    output logic             data_valid_o
);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             valid_q, valid_d;

    logic              start_w;
    logic [LANE_W-1:0] hi_q, hi_r;
    logic [WIDTH-1:0]  lo_q, lo_r;
    logic              hi_dbz, hi_done, lo_dbz, lo_done;

    assign start_w = (state_q == S_IDLE) && enable_i && (cm_i != CM_ILLEGAL);

    restoring_divide_core #(.W(LANE_W)) u_hi (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start   (start_w && (cm_i == CM_DUAL8)),
        .narrow  (1'b0),
        .a       (dividend_i[WIDTH-1:LANE_W]),
        .b       (divisor_i[WIDTH-1:LANE_W]),
        .q       (hi_q),
        .r       (hi_r),
        .dbz     (hi_dbz),
        .done    (hi_done)
    );

    restoring_divide_core #(.W(WIDTH)) u_lo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start   (start_w),
        .narrow  (cm_i != CM_SINGLE16),
        .a       (dividend_i),
        .b       (divisor_i),
        .q       (lo_q),
        .r       (lo_r),
        .dbz     (lo_dbz),
        .done    (lo_done)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d = S_CALC;
                    mode_d  = cm_i;
                end
            end
            S_CALC: begin
                if (lo_done && (hi_done || (mode_q != CM_DUAL8))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b1;
                case (mode_q)
                    CM_DUAL8: begin
                        quot_d = {hi_q, lo_q[LANE_W-1:0]};
                        rem_d  = {hi_r, lo_r[LANE_W-1:0]};
                        dbz_d  = {hi_dbz, lo_dbz};
                    end
                    CM_SINGLE16: begin
                        quot_d = lo_q;
                        rem_d  = lo_r;
                        dbz_d  = {lo_dbz, 1'b0};
                    end
                    default: begin
                        quot_d = {{LANE_W{1'b0}}, lo_q[LANE_W-1:0]};
                        rem_d  = {{LANE_W{1'b0}}, lo_r[LANE_W-1:0]};
                        dbz_d  = {1'b0, lo_dbz};
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            mode_q  <= CM_SINGLE8;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            valid_q <= valid_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign busy_o        = (state_q != S_IDLE);
    assign data_valid_o  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_configurable_divider.sv
`default_nettype none
// ============================================================================
//  Module  : tb_configurable_divider
//  Directed scoreboard bench for the configurable signed divider.
//  Revision: 1.0  initial release
// ============================================================================
module tb_configurable_divider;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [1:0]  cm_i;
    logic [15:0] dividend_i, divisor_i;
    logic [15:0] quotient_o, remainder_o;
    logic [1:0]  div_by_zero_o;
    logic        busy_o, data_valid_o;

    configurable_divider #(.WIDTH(16)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .cm_i          (cm_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o),
        .busy_o        (busy_o),
        .data_valid_o  (data_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [1:0]  dbz;
        logic [7:0]  lat;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation, scramble inputs while busy, then wait for the result
    task automatic run_op(input string tag, input logic [1:0] cm, input logic [15:0] dvd,
                          input logic [15:0] dvs, input logic [15:0] eq, input logic [15:0] er,
                          input logic [1:0] ed);
        exp_t  e;
        string t;
        int    n;
        bit    seen;
        e.q   = eq;
        e.r   = er;
        e.dbz = ed;
        e.lat = (cm == 2'b10) ? 8'd18 : 8'd10;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk_i);
        enable_i   = 1'b1;
        cm_i       = cm;
        dividend_i = dvd;
        divisor_i  = dvs;
        @(posedge clk_i);
        #1;
        check({tag, ".busy"}, 32'(busy_o), 32'd1);
        enable_i   = 1'b0;
        cm_i       = 2'($urandom);
        dividend_i = 16'($urandom);
        divisor_i  = 16'($urandom);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            if (data_valid_o) begin
                n    = k;
                seen = 1'b1;
                break;
            end
            enable_i = (k == 3);
        end
        enable_i = 1'b0;
        check({tag, ".seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".lat"}, 32'(n), 32'(e.lat));
            check({t, ".q"}, 32'(quotient_o), 32'(e.q));
            check({t, ".r"}, 32'(remainder_o), 32'(e.r));
            check({t, ".dbz"}, 32'(div_by_zero_o), 32'(e.dbz));
        end
    endtask

    initial begin
        bit any_busy, any_valid;
        reset_i    = 1'b1;
        enable_i   = 1'b0;
        cm_i       = 2'b00;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.q", 32'(quotient_o), 32'd0);
        check("rst.r", 32'(remainder_o), 32'd0);
        check("rst.dbz", 32'(div_by_zero_o), 32'd0);
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.valid", 32'(data_valid_o), 32'd0);
        reset_i = 1'b0;

        run_op("t1", 2'b10, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 2'b00);
        @(posedge clk_i);
        #1;
        check("t1.pulse", 32'(data_valid_o), 32'd0);
        check("t1.hold", 32'(quotient_o), 32'h0000FFF2);

        // Back-to-back from here on: each start lands in the IDLE cycle after DONE
        run_op("t2", 2'b01, 16'h649C, 16'h0707, 16'h0EF2, 16'h02FE, 2'b00);
        run_op("t3", 2'b00, 16'hAB32, 16'h12F9, 16'h00F9, 16'h0001, 2'b00);
        run_op("t4", 2'b01, 16'h2864, 16'h0500, 16'h08FF, 16'h0064, 2'b01);
        run_op("dz16", 2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 2'b10);
        run_op("dz8", 2'b00, 16'h7705, 16'h3300, 16'h00FF, 16'h0005, 2'b01);
        run_op("ovf8", 2'b00, 16'h0080, 16'h00FF, 16'h0080, 16'h0000, 2'b00);
        run_op("dualneg", 2'b01, 16'h8580, 16'h0BFF, 16'hF580, 16'hFE00, 2'b00);
        run_op("t5", 2'b10, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 2'b00);

        any_busy  = 1'b0;
        any_valid = 1'b0;
        @(negedge clk_i);
        enable_i   = 1'b1;
        cm_i       = 2'b11;
        dividend_i = 16'h0064;
        divisor_i  = 16'h0005;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk_i);
            #1;
            any_busy  = any_busy | busy_o;
            any_valid = any_valid | data_valid_o;
        end
        enable_i = 1'b0;
        check("ill.busy", 32'(any_busy), 32'd0);
        check("ill.valid", 32'(any_valid), 32'd0);

        any_valid = 1'b0;
        @(negedge clk_i);
        enable_i   = 1'b1;
        cm_i       = 2'b10;
        dividend_i = 16'h1234;
        divisor_i  = 16'h0005;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk_i);
            #1;
            any_valid = any_valid | data_valid_o;
            cm_i      = 2'b00;
            enable_i  = (k == 4);
        end
        enable_i = 1'b0;
        reset_i  = 1'b1;
        #1;
        check("t6.q", 32'(quotient_o), 32'd0);
        check("t6.r", 32'(remainder_o), 32'd0);
        check("t6.busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk_i);
            #1;
            any_valid = any_valid | data_valid_o;
        end
        check("t6.novalid", 32'(any_valid), 32'd0);
        run_op("t6.fresh", 2'b10, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 2'b00);

        check("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
